// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU sequencing controller: opcode values,
// result-mux (OSEL) encodings, the controller state enum and the packed
// datapath control word produced by the opcode decoder.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // Opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Result mux encodings
    localparam logic [1:0] OSEL_ADD = 2'b00;
    localparam logic [1:0] OSEL_SHF = 2'b01;
    localparam logic [1:0] OSEL_LOG = 2'b10;
    localparam logic [1:0] OSEL_ACC = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        MCLR  = 3'd2,
        MSTEP = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Datapath control word for single-cycle ops (MSB first as listed)
    typedef struct packed {
        logic       cisel;
        logic       bsel;
        logic [1:0] osel;
        logic       shift_la;
        logic       shift_lr;
        logic       logical_op;
    } ctrl_t;

    // All-zero word: the ADD encoding with nothing selected
    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_seq_control_if.sv
// ---------------------------------------------------------------------------
// alu_seq_control_if
// Bundle between instruction-issue logic (master) and the ALU sequencing
// controller (slave).
//   master drives : start, op, abort
//   slave drives  : busy, done, datapath controls, step, dbg_state
// Handshake: the master raises start with op valid; the request is taken
// only on a clock edge where the controller is IDLE and abort is low. busy
// rises the cycle after acceptance and done pulses for one cycle when the
// op completes. start while busy is dropped, never queued. abort cancels
// any in-flight op without a done pulse.
// ---------------------------------------------------------------------------
interface alu_seq_control_if import alu_ctrl_pkg::*; #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH);

    logic          start;
    logic [2:0]    op;
    logic          abort;
    logic          busy;
    logic          done;
    logic          cisel;
    logic          bsel;
    logic [1:0]    osel;
    logic          shift_la;
    logic          shift_lr;
    logic          logical_op;
    logic          res_en;
    logic          acc_clr;
    logic          acc_en;
    logic [CW-1:0] step;
    state_t        dbg_state;

    modport master (
        output start, op, abort,
        input  busy, done, cisel, bsel, osel, shift_la, shift_lr,
               logical_op, res_en, acc_clr, acc_en, step, dbg_state
    );

    modport slave (
        input  start, op, abort,
        output busy, done, cisel, bsel, osel, shift_la, shift_lr,
               logical_op, res_en, acc_clr, acc_en, step, dbg_state
    );
endinterface

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode -> datapath control word mapping.
//   op   : 3-bit opcode
//   ctrl : {cisel, bsel, osel, shift_la, shift_lr, logical_op}
// MUL maps to the accumulator result path; its enables come from the
// sequencer, not from here.
// ---------------------------------------------------------------------------
module alu_op_decode import alu_ctrl_pkg::*; (
    input  logic [2:0] op,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = CTRL_NONE;
        case (op)
            OP_ADD: ctrl = CTRL_NONE;
            OP_SUB: begin
                ctrl.cisel = 1'b1;
                ctrl.bsel  = 1'b1;
                ctrl.osel  = OSEL_ADD;
            end
            OP_SRA: begin
                ctrl.osel     = OSEL_SHF;
                ctrl.shift_la = 1'b1;
                ctrl.shift_lr = 1'b1;
            end
            OP_SRL: begin
                ctrl.osel     = OSEL_SHF;
                ctrl.shift_lr = 1'b1;
            end
            OP_SLL: ctrl.osel = OSEL_SHF;
            OP_OR: begin
                ctrl.osel       = OSEL_LOG;
                ctrl.logical_op = 1'b1;
            end
            OP_AND: ctrl.osel = OSEL_LOG;
            OP_MUL: ctrl.osel = OSEL_ACC;
            default: ctrl = CTRL_NONE;
        endcase
    end
endmodule

// File: rtl/alu_seq_control.sv
// ---------------------------------------------------------------------------
// alu_seq_control
// Sequences ALU datapath controls: one EXEC cycle for single-cycle ops and
// a WIDTH-step shift-add multiply for MUL.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_seq_control_if.slave (start/op/abort in; busy, done,
//             datapath controls, step and dbg_state out)
// Every output is decoded only from the state, step and latched control
// flops, so start/op have no combinational path to the outputs.
// ---------------------------------------------------------------------------
module alu_seq_control import alu_ctrl_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_seq_control_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    ctrl_t         ctrl_q, ctrl_dec;
    logic          accept;
    logic          last_step;

    alu_op_decode u_dec (
        .op   (bus.op),
        .ctrl (ctrl_dec)
    );

    // abort together with start in IDLE drops the request
    assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
    assign last_step = (step_q == LAST_STEP);

    // Next-state and step counter
    always_comb begin
        state_d = state_q;
        step_d  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.op == OP_MUL) ? MCLR : EXEC;
                end
            end
            EXEC: state_d = FIN;
            MCLR: state_d = MSTEP;
            MSTEP: begin
                if (last_step) begin
                    state_d = FIN;
                end else begin
                    state_d = MSTEP;
                    step_d  = step_q + CW'(1);
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort overrides every transition
        if (bus.abort) begin
            state_d = IDLE;
            step_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            ctrl_q  <= CTRL_NONE;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            // Latching the decoded word makes later op changes irrelevant
            if (accept) begin
                ctrl_q <= ctrl_dec;
            end
        end
    end

    // Output decode from flops only
    ctrl_t         ctrl_out;
    logic          done_o, res_en_o, acc_clr_o, acc_en_o;
    logic [CW-1:0] step_o;

    always_comb begin
        ctrl_out  = CTRL_NONE;
        done_o    = 1'b0;
        res_en_o  = 1'b0;
        acc_clr_o = 1'b0;
        acc_en_o  = 1'b0;
        step_o    = '0;
        case (state_q)
            EXEC: begin
                ctrl_out = ctrl_q;
                res_en_o = 1'b1;
            end
            MCLR: acc_clr_o = 1'b1;
            MSTEP: begin
                ctrl_out.osel = OSEL_ACC;
                acc_en_o      = 1'b1;
                res_en_o      = last_step;
                step_o        = step_q;
            end
            FIN: done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_o;
    assign bus.cisel      = ctrl_out.cisel;
    assign bus.bsel       = ctrl_out.bsel;
    assign bus.osel       = ctrl_out.osel;
    assign bus.shift_la   = ctrl_out.shift_la;
    assign bus.shift_lr   = ctrl_out.shift_lr;
    assign bus.logical_op = ctrl_out.logical_op;
    assign bus.res_en     = res_en_o;
    assign bus.acc_clr    = acc_clr_o;
    assign bus.acc_en     = acc_en_o;
    assign bus.step       = step_o;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_alu_seq_control.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_control
// Directed bench for alu_seq_control with WIDTH=8 and WIDTH=4 instances.
// Observed output vector layout:
//   {busy, done, cisel, bsel, osel[1:0], shift_la, shift_lr, logical_op,
//    res_en, acc_clr, acc_en, step}
// ---------------------------------------------------------------------------
module tb_alu_seq_control;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    alu_seq_control_if #(.WIDTH(8)) b8 ();
    alu_seq_control_if #(.WIDTH(4)) b4 ();

    alu_seq_control #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(b8));
    alu_seq_control #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- hand-computed control words {cisel,bsel,osel,la,lr,lop} ----
    logic [2:0] op_tab  [7];
    logic [6:0] ctl_tab [7];
    initial begin
        op_tab[0] = 3'b000; ctl_tab[0] = 7'b00_00_000; // ADD
        op_tab[1] = 3'b001; ctl_tab[1] = 7'b11_00_000; // SUB
        op_tab[2] = 3'b010; ctl_tab[2] = 7'b00_01_110; // SRA
        op_tab[3] = 3'b011; ctl_tab[3] = 7'b00_01_010; // SRL
        op_tab[4] = 3'b100; ctl_tab[4] = 7'b00_01_000; // SLL
        op_tab[5] = 3'b101; ctl_tab[5] = 7'b00_10_001; // OR
        op_tab[6] = 3'b110; ctl_tab[6] = 7'b00_10_000; // AND
    end

    localparam logic [6:0] CTL_MUL = 7'b00_11_000;

    function automatic logic [14:0] obs8();
        return {b8.busy, b8.done, b8.cisel, b8.bsel, b8.osel, b8.shift_la,
                b8.shift_lr, b8.logical_op, b8.res_en, b8.acc_clr, b8.acc_en,
                b8.step};
    endfunction

    function automatic logic [13:0] obs4();
        return {b4.busy, b4.done, b4.cisel, b4.bsel, b4.osel, b4.shift_la,
                b4.shift_lr, b4.logical_op, b4.res_en, b4.acc_clr, b4.acc_en,
                b4.step};
    endfunction

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic start, input logic [2:0] op, input logic abort);
        b8.start = start;
        b8.op    = op;
        b8.abort = abort;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [14:0] o;
        reset_n = 1'b0;
        drive8(1'b0, 3'b000, 1'b0);
        b4.start = 1'b0; b4.op = 3'b000; b4.abort = 1'b0;
        tick();
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=%h", o, 15'h0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs8();
            vectors++;
            if (o !== 15'h0) begin
                miscompares++;
                $display("FAIL idle_after_reset[%0d] got=%h exp=%h", i, o, 15'h0);
            end
        end
    endtask

    task automatic test_sub();
        logic [14:0] o, e;
        drive8(1'b1, 3'b001, 1'b0);
        tick();
        drive8(1'b0, 3'b000, 1'b0);
        o = obs8(); e = {2'b10, 7'b11_00_000, 3'b100, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL sub_exec got=%h exp=%h", o, e);
        end
        tick();
        o = obs8(); e = {2'b11, 7'b0, 3'b000, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL sub_fin got=%h exp=%h", o, e);
        end
        tick();
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL sub_idle got=%h exp=%h", o, 15'h0);
        end
    endtask

    // start stays high through every busy cycle; op is scrambled while busy
    task automatic test_back_to_back();
        logic [14:0] o, e;
        for (int i = 0; i < 7; i++) begin
            drive8(1'b1, op_tab[i], 1'b0);
            tick();
            drive8(1'b1, 3'b111, 1'b0);
            o = obs8(); e = {2'b10, ctl_tab[i], 3'b100, 3'd0};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL sweep_exec op=%0d got=%h exp=%h", i, o, e);
            end
            tick();
            o = obs8(); e = {2'b11, 7'b0, 3'b000, 3'd0};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL sweep_fin op=%0d got=%h exp=%h", i, o, e);
            end
            tick();
            o = obs8();
            vectors++;
            if (o !== 15'h0) begin
                miscompares++;
                $display("FAIL sweep_idle op=%0d got=%h exp=%h", i, o, 15'h0);
            end
        end
        drive8(1'b0, 3'b000, 1'b0);
        tick();
    endtask

    task automatic test_mul8();
        logic [14:0] o, e;
        drive8(1'b1, 3'b111, 1'b0);
        tick();
        drive8(1'b0, 3'b000, 1'b0);
        o = obs8(); e = {2'b10, 7'b0, 3'b010, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mul8_clr got=%h exp=%h", o, e);
        end
        for (int s = 0; s < 8; s++) begin
            tick();
            o = obs8();
            e = {2'b10, CTL_MUL, (s == 7) ? 1'b1 : 1'b0, 2'b01, 3'(s)};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mul8_step[%0d] got=%h exp=%h", s, o, e);
            end
        end
        tick();
        o = obs8(); e = {2'b11, 7'b0, 3'b000, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mul8_fin got=%h exp=%h", o, e);
        end
        tick();
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL mul8_idle got=%h exp=%h", o, 15'h0);
        end
    endtask

    task automatic test_mul4();
        logic [13:0] o, e;
        b4.start = 1'b1; b4.op = 3'b111; b4.abort = 1'b0;
        tick();
        b4.start = 1'b0; b4.op = 3'b000;
        o = obs4(); e = {2'b10, 7'b0, 3'b010, 2'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mul4_clr got=%h exp=%h", o, e);
        end
        for (int s = 0; s < 4; s++) begin
            tick();
            o = obs4();
            e = {2'b10, CTL_MUL, (s == 3) ? 1'b1 : 1'b0, 2'b01, 2'(s)};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mul4_step[%0d] got=%h exp=%h", s, o, e);
            end
        end
        tick();
        o = obs4(); e = {2'b11, 7'b0, 3'b000, 2'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mul4_fin_cycle6 got=%h exp=%h", o, e);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [14:0] o, e;
        // abort with start in IDLE: request dropped
        drive8(1'b1, 3'b001, 1'b1);
        tick();
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL abort_start_idle got=%h exp=%h", o, 15'h0);
        end
        drive8(1'b1, 3'b111, 1'b0);
        tick();                               // MCLR
        drive8(1'b0, 3'b000, 1'b0);
        for (int s = 0; s < 4; s++) tick();   // MSTEP step 3
        o = obs8(); e = {2'b10, CTL_MUL, 3'b001, 3'd3};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL abort_at_step3 got=%h exp=%h", o, e);
        end
        drive8(1'b0, 3'b000, 1'b1);
        tick();
        drive8(1'b1, 3'b110, 1'b0);
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL abort_idle got=%h exp=%h", o, 15'h0);
        end
        tick();
        drive8(1'b0, 3'b000, 1'b0);
        o = obs8(); e = {2'b10, 7'b00_10_000, 3'b100, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL abort_restart got=%h exp=%h", o, e);
        end
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        logic [14:0] o, e;
        drive8(1'b1, 3'b111, 1'b0);
        tick();
        drive8(1'b0, 3'b000, 1'b0);
        for (int s = 0; s < 6; s++) tick();   // MSTEP step 5
        o = obs8(); e = {2'b10, CTL_MUL, 3'b001, 3'd5};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL pre_reset_step5 got=%h exp=%h", o, e);
        end
        #1 reset_n = 1'b0;
        #1;
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", o, 15'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        o = obs8();
        vectors++;
        if (o !== 15'h0) begin
            miscompares++;
            $display("FAIL post_reset_idle got=%h exp=%h", o, 15'h0);
        end
        drive8(1'b1, 3'b000, 1'b0);
        tick();
        drive8(1'b0, 3'b000, 1'b0);
        o = obs8(); e = {2'b10, 7'b0, 3'b100, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset_add_exec got=%h exp=%h", o, e);
        end
        tick();
        o = obs8(); e = {2'b11, 7'b0, 3'b000, 3'd0};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset_add_fin got=%h exp=%h", o, e);
        end
        tick();
    endtask

    // ---- sequence and report ----
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sub();
        test_back_to_back();
        test_mul8();
        test_mul4();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
